// File: rtl/multiplier_if.sv
// rtl/multiplier_if.sv - start/operand/result bundle between a requester and the shift-add multiplier
interface multiplier_if #(
  parameter int M = 26,
  parameter int N = 14
);
  logic           en;
  logic [M-1:0]   multi1;
  logic [N-1:0]   multi2;
  logic [M+N-1:0] product;
  logic           busy;
  logic           done;

  modport master (output en, multi1, multi2, input product, busy, done);
  modport slave  (input en, multi1, multi2, output product, busy, done);
endinterface

// File: rtl/multiplier.sv
// rtl/multiplier.sv - sequential shift-add unsigned multiplier, M x N -> M+N bits
// Define MULT_RADIX4_EN for the two-bits-per-cycle datapath (ceil(N/2) cycles instead of N).
module multiplier #(
  parameter int M = 26,
  parameter int N = 14
) (
  input logic        clk,
  input logic        rst_n,
  multiplier_if.slave bus
);
  localparam int W = M + N;
`ifdef MULT_RADIX4_EN
  localparam int STEPS = (N + 1) / 2;
`else
  localparam int STEPS = N;
`endif
  localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic          en_q;
  logic          start;
  logic          last;
  logic [M-1:0]  mcand;
  logic [N-1:0]  mplier;
  logic [CW-1:0] count;
  logic [W-1:0]  acc;
  logic [W-1:0]  addend;
  logic [W-1:0]  sum;
  logic [W-1:0]  product_q;
  logic          busy_q;
  logic          done_q;
`ifdef MULT_RADIX4_EN
  logic [M+1:0]  mcand3;
  logic [W-1:0]  pp;
`endif

  assign start = bus.en & ~en_q;
  assign last  = (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = BUSY;
      BUSY:    if (last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef MULT_RADIX4_EN
  // 3x multiplicand is latched at start so every step is a single add
  always_comb begin
    pp = '0;
    case (mplier[1:0])
      2'd1:    pp = W'(mcand);
      2'd2:    pp = W'(mcand) << 1;
      2'd3:    pp = W'(mcand3);
      default: pp = '0;
    endcase
    addend = pp << {count, 1'b0};
    sum    = acc + addend;
  end
`else
  always_comb begin
    addend = mplier[0] ? (W'(mcand) << count) : '0;
    sum    = acc + addend;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q      <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      count     <= '0;
      acc       <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef MULT_RADIX4_EN
      mcand3    <= '0;
`endif
    end else begin
      en_q   <= bus.en;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand  <= bus.multi1;
            mplier <= bus.multi2;
            acc    <= '0;
            count  <= '0;
            busy_q <= 1'b1;
`ifdef MULT_RADIX4_EN
            mcand3 <= {2'b00, bus.multi1} + {1'b0, bus.multi1, 1'b0};
`endif
          end
        end
        BUSY: begin
          acc   <= sum;
          count <= count + 1'b1;
`ifdef MULT_RADIX4_EN
          mplier <= mplier >> 2;
`else
          mplier <= mplier >> 1;
`endif
          // final partial sum goes straight to the output register
          if (last) begin
            product_q <= sum;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.product = product_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_multiplier.sv
// tb/tb_multiplier.sv - randomized self-checking bench for multiplier against an arithmetic model
module tb_multiplier;
  localparam int M = 26;
  localparam int N = 14;
`ifdef MULT_RADIX4_EN
  localparam int LAT = (N + 1) / 2;
`else
  localparam int LAT = N;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  multiplier_if #(.M(M), .N(N)) bus ();
  multiplier #(.M(M), .N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  function automatic logic [M+N-1:0] model(input logic [M-1:0] a, input logic [N-1:0] b);
    return (M+N)'(64'(a) * 64'(b));
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [M-1:0] a, input logic [N-1:0] b);
    bus.multi1 = a;
    bus.multi2 = b;
    bus.en     = 1'b1;
    tick();
    check("busy_start", 64'(bus.busy), 64'd1);
  endtask

  task automatic wait_done(input logic [M+N-1:0] exp, input bit scramble, input bit en_after);
    logic [M+N-1:0] prev;
    int cyc;
    bit seen;
    prev = bus.product;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < LAT + 4) begin
      if (scramble && cyc + 1 < LAT) begin
        bus.multi1 = M'($urandom);
        bus.multi2 = N'($urandom);
        bus.en     = 1'($urandom);
      end else begin
        bus.en = en_after;
      end
      tick();
      cyc++;
      seen = bus.done;
      if (!seen) check("product_hold", 64'(bus.product), 64'(prev));
    end
    check("latency", 64'(cyc), 64'(LAT));
    check("product", 64'(bus.product), 64'(exp));
    check("busy_clear", 64'(bus.busy), 64'd0);
  endtask

  task automatic after_done(input logic [M+N-1:0] exp);
    tick();
    check("done_one_cycle", 64'(bus.done), 64'd0);
    check("product_keep", 64'(bus.product), 64'(exp));
  endtask

  task automatic run_op(input logic [M-1:0] a, input logic [N-1:0] b, input bit scramble);
    bus.en = 1'b0;
    tick();
    start_op(a, b);
    wait_done(model(a, b), scramble, 1'b1);
    after_done(model(a, b));
  endtask

  initial begin
    logic [M-1:0] a;
    logic [N-1:0] b;
    int pulses;

    rst_n      = 1'b0;
    bus.en     = 1'b0;
    bus.multi1 = '0;
    bus.multi2 = '0;
    tick();
    tick();
    check("rst_product", 64'(bus.product), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    rst_n = 1'b1;
    tick();

    run_op(26'h0050A01, 14'h3024, 1'b0);
    check("default_value", 64'(bus.product), 64'd4069890084);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.done) pulses++;
      if (bus.busy) pulses++;
    end
    check("no_retrigger", 64'(pulses), 64'd0);
    check("default_stable", 64'(bus.product), 64'd4069890084);

    run_op({M{1'b1}}, {N{1'b1}}, 1'b0);
    run_op('0, {N{1'b1}}, 1'b0);
    run_op({M{1'b1}}, '0, 1'b0);

    // operands and en are scrambled while the operation runs
    run_op(26'h1234567, 14'h2ABC, 1'b1);

    // back-to-back: en drops after the start, rises right after done
    bus.en = 1'b0;
    tick();
    start_op(26'h3FF00FF, 14'h1111);
    wait_done(model(26'h3FF00FF, 14'h1111), 1'b0, 1'b0);
    start_op(26'd3, 14'd5);
    wait_done(40'd15, 1'b0, 1'b1);
    after_done(40'd15);

    // asynchronous reset in the middle of an operation
    bus.en = 1'b0;
    tick();
    start_op(26'h2AAAAAA, 14'h1555);
    bus.en = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_product", 64'(bus.product), 64'd0);
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_done", 64'(bus.done), 64'd0);
    tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < LAT + 3; i++) begin
      tick();
      if (bus.done) pulses++;
    end
    check("midrst_no_done", 64'(pulses), 64'd0);
    check("midrst_product_zero", 64'(bus.product), 64'd0);
    run_op(26'h0ABCDEF, 14'h0777, 1'b0);

    for (int i = 0; i < 24; i++) begin
      a = M'($urandom);
      b = N'($urandom);
      if (i % 8 == 3) b = {N{1'b1}};
      if (i % 8 == 5) a = {M{1'b1}};
      run_op(a, b, i[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
